// File: rtl/i2c_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_config_sequencer
// Brief    : Walks a config ROM at power-up, sending each 16-bit word to an
//            I2C codec as three bytes (addr+W, high, low) with NACK retries.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_config_sequencer #(
  parameter int         NUM_WORDS      = 10,
  parameter logic [6:0] DEV_ADDR       = 7'h1A,
  parameter int         POWERUP_CYCLES = 1000,
  parameter int         GAP_CYCLES     = 100,
  parameter int         MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  rom_index,
  input  logic [15:0] rom_word,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_byte,
  output logic        cmd_start,
  output logic        cmd_stop,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  state_info
);

  localparam int c_MAX_WAIT = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W    = $clog2(c_MAX_WAIT + 1);
  localparam int c_RETRY_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [c_CNT_W-1:0]   c_PU_LAST   = c_CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]   c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRIES);
  localparam logic [7:0]           c_LAST_IDX  = 8'(NUM_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_POWERUP  = 4'd1,
    S_ISSUE    = 4'd2,
    S_WAIT_RSP = 4'd3,
    S_GAP      = 4'd4,
    S_DONE     = 4'd5,
    S_ERROR    = 4'd6
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_RETRY_W-1:0] r_retry_cnt;
  logic [1:0]           r_byte_sel;
  logic [7:0]           r_rom_index;
  logic                 r_cmd_valid;
  logic [7:0]           r_cmd_byte;
  logic                 r_cmd_start;
  logic                 r_cmd_stop;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic [1:0]           w_issue_sel;

  // Byte about to be issued: the next byte of the word after an ACK, else the address byte.
  assign w_issue_sel = (r_state == S_WAIT_RSP) ? r_byte_sel + 2'd1 : 2'd0;

  function automatic logic [7:0] sel_byte(input logic [1:0] sel, input logic [15:0] word);
    case (sel)
      2'd0:    return {DEV_ADDR, 1'b0};
      2'd1:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_byte_sel  <= '0;
      r_rom_index <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_byte  <= '0;
      r_cmd_start <= 1'b0;
      r_cmd_stop  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state     <= S_POWERUP;
            r_cnt       <= '0;
            r_retry_cnt <= '0;
            r_byte_sel  <= '0;
            r_rom_index <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
          end
        end
        S_POWERUP, S_GAP: begin
          if (r_cnt == ((r_state == S_POWERUP) ? c_PU_LAST : c_GAP_LAST)) begin
            r_cnt       <= '0;
            r_byte_sel  <= 2'd0;
            r_state     <= S_ISSUE;
            r_cmd_valid <= 1'b1;
            r_cmd_byte  <= sel_byte(w_issue_sel, rom_word);
            r_cmd_start <= 1'b1;
            r_cmd_stop  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_valid) begin
            if (rsp_nack) begin
              // The master has already closed the transfer; resend the whole word.
              if (r_retry_cnt < c_MAX_RETRY) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
                r_byte_sel  <= 2'd0;
                r_cnt       <= '0;
                r_state     <= S_GAP;
              end else begin
                r_state <= S_ERROR;
                r_busy  <= 1'b0;
                r_error <= 1'b1;
              end
            end else if (r_byte_sel != 2'd2) begin
              r_byte_sel  <= w_issue_sel;
              r_state     <= S_ISSUE;
              r_cmd_valid <= 1'b1;
              r_cmd_byte  <= sel_byte(w_issue_sel, rom_word);
              r_cmd_start <= 1'b0;
              r_cmd_stop  <= (w_issue_sel == 2'd2);
            end else begin
              r_retry_cnt <= '0;
              if (r_rom_index == c_LAST_IDX) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_rom_index <= r_rom_index + 8'd1;
                r_cnt       <= '0;
                r_state     <= S_GAP;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_index  = r_rom_index;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_byte   = r_cmd_byte;
  assign cmd_start  = r_cmd_start;
  assign cmd_stop   = r_cmd_stop;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign state_info = r_state;

endmodule
`default_nettype wire
